// File: rtl/seg7_scan8.sv
// Eight-digit multiplexed common-anode seven-segment scan driver with per-frame input snapshot.
// Define SEG7_LZ_BLANK_EN to blank leading-zero digits above the highest non-zero nibble.
module seg7_scan8 #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [31:0] iData,
  input  logic [7:0]  iDigitEn,
  input  logic [7:0]  iDp,
  output logic [6:0]  oSeg,
  output logic        oDp,
  output logic [7:0]  oAn
);

  localparam logic [19:0] CNT_MAX = 20'(REFRESH_DIV - 1);

  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  en_q, en_d;
  logic [7:0]  dpm_q, dpm_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        pt_q, pt_d;

  logic        wrap;
  logic        frame_end;
  logic [3:0]  nib;
  logic [6:0]  glyph;
  logic        lit;
`ifdef SEG7_LZ_BLANK_EN
  logic [2:0]  hi;
`endif

  always_comb begin
    wrap      = (cnt_q == CNT_MAX);
    frame_end = wrap && (idx_q == 3'd7);
    cnt_d     = wrap ? '0 : cnt_q + 20'd1;
    idx_d     = wrap ? idx_q + 3'd1 : idx_q;
    // Shadows only move at the 7->0 wrap so a frame never shows mixed data.
    data_d    = frame_end ? iData    : data_q;
    en_d      = frame_end ? iDigitEn : en_q;
    dpm_d     = frame_end ? iDp      : dpm_q;
  end

  always_comb begin
    nib = data_q[4*idx_q +: 4];
    case (nib)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  end

`ifdef SEG7_LZ_BLANK_EN
  always_comb begin
    hi = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (data_q[4*i +: 4] != 4'h0) hi = 3'(i);
    end
    lit = en_q[idx_q] && (idx_q <= hi);
  end
`else
  always_comb begin
    lit = en_q[idx_q];
  end
`endif

  always_comb begin
    an_d  = '1;
    seg_d = '1;
    pt_d  = 1'b1;
    if (lit) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = glyph;
      pt_d  = ~dpm_q[idx_q];
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      en_q   <= '0;
      dpm_q  <= '0;
      an_q   <= '1;
      seg_q  <= '1;
      pt_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      en_q   <= en_d;
      dpm_q  <= dpm_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      pt_q   <= pt_d;
    end
  end

  assign oAn  = an_q;
  assign oSeg = seg_q;
  assign oDp  = pt_q;

endmodule

// File: tb/tb_seg7_scan8.sv
// Self-checking bench for seg7_scan8: edge-count reference model plus directed scenarios and random traffic.
module tb_seg7_scan8;

  localparam int unsigned R = 4;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [31:0] iData;
  logic [7:0]  iDigitEn;
  logic [7:0]  iDp;
  logic [6:0]  oSeg;
  logic        oDp;
  logic [7:0]  oAn;

  int checks   = 0;
  int failures = 0;

  seg7_scan8 #(.REFRESH_DIV(R)) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .iData    (iData),
    .iDigitEn (iDigitEn),
    .iDp      (iDp),
    .oSeg     (oSeg),
    .oDp      (oDp),
    .oAn      (oAn)
  );

  always #5 CLK = ~CLK;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference: n = clock edges since reset release; after edge n the scan sits on digit (n/R)%8,
  // and the outputs seen after edge n describe the state left by edge n-1.
  int unsigned n;
  int unsigned d;
  int unsigned h;
  logic [31:0] sh_data;
  logic [7:0]  sh_en, sh_dp;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [31:0] tmp;
  bit          show;

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; sh_data = '0; sh_en = '0; sh_dp = '0;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      d = (n / R) % 8;
      h = 0;
      for (int i = 0; i < 8; i++) if (((sh_data >> (4*i)) & 32'hF) != 0) h = i;
      show = sh_en[d];
`ifdef SEG7_LZ_BLANK_EN
      if (d > h) show = 1'b0;
`endif
      if (show) begin
        exp_an  = ~(8'd1 << d);
        tmp     = (sh_data >> (4*d)) & 32'hF;
        exp_seg = seg_tab[tmp[3:0]];
        exp_dp  = ~sh_dp[d];
      end else begin
        exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end
      n = n + 1;
      if (n % (8*R) == 0) begin
        sh_data = iData; sh_en = iDigitEn; sh_dp = iDp;
      end
    end
  end

  task automatic chk(input string tag);
    checks++;
    assert (oAn === exp_an) else begin
      failures++; $error("FAIL %s oAn=%h expected=%h", tag, oAn, exp_an);
    end
    checks++;
    assert (oSeg === exp_seg) else begin
      failures++; $error("FAIL %s oSeg=%b expected=%b", tag, oSeg, exp_seg);
    end
    checks++;
    assert (oDp === exp_dp) else begin
      failures++; $error("FAIL %s oDp=%b expected=%b", tag, oDp, exp_dp);
    end
  endtask

  task automatic run(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      chk(tag);
    end
  endtask

  task automatic wait_idx(input string tag, input int unsigned target);
    int k;
    k = 0;
    while (((n / R) % 8) != target && k < 40) begin
      @(negedge CLK);
      chk(tag);
      k++;
    end
    checks++;
    assert (k < 40) else begin
      failures++; $error("FAIL %s_timeout waited=%0d expected<40", tag, k);
    end
  endtask

  task automatic direct(input string tag, input logic [7:0] an, input logic [6:0] seg);
    checks++;
    assert (oAn === an) else begin
      failures++; $error("FAIL %s oAn=%h expected=%h", tag, oAn, an);
    end
    checks++;
    assert (oSeg === seg) else begin
      failures++; $error("FAIL %s oSeg=%b expected=%b", tag, oSeg, seg);
    end
  endtask

  initial begin
    rst_n = 1'b0; iData = 32'h0000_0005; iDigitEn = 8'h01; iDp = 8'h00;
    // Reset and blank first frame
    run("reset", 3);
    direct("reset_const", 8'hFF, 7'h7F);
    rst_n = 1'b1;
    run("first_frame", 32);
    direct("first_frame_end", 8'hFF, 7'h7F);
    run("first_live", 1);
    direct("first_live", 8'hFE, 7'b0010010);
    run("first_live_rest", 8);

    // Full scan with decimal point on digit 7
    iData = 32'h89AB_CDEF; iDigitEn = 8'hFF; iDp = 8'h80;
    run("full_scan", 64);

    // Tear-free snapshot: change while scanning digit 3
    iData = 32'h1111_1111;
    run("tear_pre", 40);
    wait_idx("tear_wait", 3);
    iData = 32'h2222_2222;
    run("tear", 64);

    // Asynchronous reset mid-frame at digit 5
    wait_idx("rst_wait", 5);
    #2 rst_n = 1'b0;
    #1 direct("rst_async", 8'hFF, 7'h7F);
    chk("rst_async_model");
    run("rst_hold", 2);
    rst_n = 1'b1;
    run("rst_restart", 40);

    // Leading-zero scenarios
    iData = 32'h0000_0305; iDigitEn = 8'hFF; iDp = 8'h00;
    run("lz_305", 72);
    iData = 32'h0000_0000;
    run("lz_zero", 72);

    // Random traffic
    for (int t = 0; t < 24; t++) begin
      iData    = $urandom;
      iDigitEn = 8'($urandom);
      iDp      = 8'($urandom);
      run("random", int'($urandom_range(3, 45)));
    end
    run("random_tail", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan8.md
# seg7_scan8

Eight-digit multiplexed seven-segment scan driver, the display stage downstream of the team's counters. It replaces the single-digit `display7` hookup with a time-multiplexed driver for the board's 8-digit common-anode display. It latches a 32-bit hex word once per frame, so values cannot tear mid-frame. It then cycles the anodes, one digit at a time, at a fixed refresh rate. The counter output, e.g. `{29'b0, oQ}`, connects directly to `iData`.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000. Clock cycles each digit is driven. Legal range is 2 to 2^20.

Ports:
- `CLK`, in, 1. System clock, 100 MHz on the board.
- `rst_n`, in, 1. Reset, asynchronous and active-low.
- `iData`, in, 32. Eight hex nibbles. Digit k is `iData[4k+3:4k]`, and digit 0 is the rightmost.
- `iDigitEn`, in, 8. Per-digit enable. 1 means the digit is displayed.
- `iDp`, in, 8. Per-digit decimal point. 1 means the point is lit.
- `oSeg`, out, 7. Segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `oDp`, out, 1. Decimal-point cathode, active-low.
- `oAn`, out, 8. Digit anodes, active-low. At most one bit is 0 at any time.

## Operation
- Slot counter `cnt` runs 0 to REFRESH_DIV-1 and wraps.
- Digit index `idx` (3 bits) increments when `cnt` wraps, and wraps from 7 to 0.
- A frame is 8×REFRESH_DIV cycles.
- Snapshot:
  - `iData`, `iDigitEn` and `iDp` are captured into shadow registers on the edge where `cnt`=REFRESH_DIV-1 and `idx`=7, i.e. the edge where `idx` wraps to 0.
  - Input changes at any other time have no effect until the next frame.
- Decode of the shadow nibble at `idx`, all active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Output mapping:
  - Enabled digit: `oAn` = ~(1<<`idx`), `oSeg` = decoded value, `oDp` = ~shadow_dp[`idx`].
  - Disabled digit: `oAn` = 8'hFF, `oSeg` = 7'h7F, `oDp` = 1.
- All outputs are registered. No combinational path runs from any input to any output.

## Timing
- Reset values:
  - `cnt`=0, `idx`=0, all shadow registers 0.
  - `oAn`=8'hFF, `oSeg`=7'h7F, `oDp`=1.
- The first frame after reset release is fully blank, because the enable shadow is 0. The first live data appears one cycle after the first `idx` 7→0 wrap, i.e. at cycle 8×REFRESH_DIV+1.
- Output latency: `oAn`, `oSeg` and `oDp` reflect the current `idx` one clock after `idx` changes.
- A simultaneous input change and snapshot edge captures the value present before the edge.
- Reset asserted mid-frame returns all state and outputs to reset values immediately, asynchronously. Scanning restarts at digit 0 with `cnt`=0.
- An `iData` value held constant produces a periodic `oAn` sequence FE, FD, FB, F7, EF, DF, BF, 7F, FE, and so on, with REFRESH_DIV cycles per step.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero blanking is active.
  - Let h be the highest digit index whose shadow nibble is non-zero, with h=0 if all nibbles are 0.
  - Digits with index > h are forced blank, exactly as if disabled, regardless of `iDigitEn`.
  - Digit 0 is never blanked by this rule.
  - h is computed from the shadow registers, so it is stable across the frame.
- `SEG7_LZ_BLANK_EN` undefined: only `iDigitEn` controls blanking, and zeros display as "0".

## Test plan
All scenarios run with REFRESH_DIV=4.
- Reset/first frame: hold `rst_n`=0 for 3 cycles, then release with `iData`=32'h0000_0005 and `iDigitEn`=8'h01. Required:
  - `oAn`=FF, `oSeg`=7F and `oDp`=1 throughout reset and the whole first frame (cycles 1–32).
  - Then `oAn`=FE and `oSeg`=0010010.
- Full scan: `iData`=32'h89AB_CDEF, `iDigitEn`=FF, `iDp`=8'h80. Across one frame:
  - `oAn` steps FE..7F, each held 4 cycles.
  - `oSeg` steps F, E, d, C, b, A, 9, 8.
  - `oDp`=0 only while `oAn`=7F.
- Tear-free snapshot: change `iData` from 32'h1111_1111 to 32'h2222_2222 while `idx`=3. Required:
  - Digits 3–7 of the current frame still show "1".
  - The next frame shows "2" on all digits.
- Mid-frame reset: assert `rst_n`=0 while `idx`=5. Required:
  - In the same cycle, asynchronously, `oAn`=FF and `oSeg`=7F.
  - After release, the scan restarts with a blank frame, then digit 0.
- Leading-zero blanking: `iData`=32'h0000_0305, `iDigitEn`=FF.
  - With `SEG7_LZ_BLANK_EN` defined, digits 0–2 show 5, 0, 3, and digits 3–7 are dark (`oAn`=FF in those slots).
  - With it undefined, digits 3–7 show "0".
  - With `iData`=0 and the macro defined, only digit 0 shows "0".
